jtopl_slot_acc: RTL and testbench
=================================

// Module: jtopl_slot_acc
// PURPOSE
//  Receiving end of the slot-serial operator pipeline. Follows the 18-slot frame
//  marked by zero/group/subslot/op and sums the outputs of every audible operator.
//  Emits one saturated mono sample per frame, with a one-clock valid strobe.
//  Checks frame alignment and flags loss of sync. Sits between the last operator stage and the sound output.
// PARAMETERS
//  OPW    13  width of signed operator output
//  OUTW   16  width of signed output sample
//  SLOTS  18  operator slots per frame
// PORTS
//  clk        in   1     system clock
//  rst        in   1     synchronous reset, active-high
//  cen        in   1     clock enable; all inputs sampled only when cen=1
//  zero       in   1     high on slot 0 of the frame
//  group      in   2     channel group 0..2 of the current slot
//  subslot    in   3     subslot 0..5 within the group
//  op         in   1     0 = modulator, 1 = carrier
//  con        in   1     channel connection of the current slot: 1 = additive (modulator audible)
//  op_result  in   OPW   signed operator output, aligned to zero/group/subslot/op
//  snd        out  OUTW  signed mixed sample, held between frames
//  snd_valid  out  1     one-clk pulse when snd updates
//  sync_err   out  1     one-clk pulse on any alignment fault
// BEHAVIOUR
//  - Reset: snd=0, snd_valid=0, sync_err=0, acc=0, idx=0, state=UNLOCKED.
//    Reset wins over cen. Reset mid-frame discards the partial sum.
//  - State machine:
//    - UNLOCKED: ignore op_result until a cen cycle with zero=1.
//      Then idx<=1, acc<=contribution of that slot, state=LOCKED. No snd_valid on this first lock.
//    - LOCKED, each cen cycle:
//      - Expected position = idx.
//      - Consistency: group*6+subslot must equal idx, and op must equal (subslot>=3).
//    - Frame end: zero=1 arrives with idx==0 (i.e. after slot 17):
//      - snd <= sat(acc); snd_valid=1 on that same clk.
//      - acc <= contribution of the new slot 0; idx<=1.
//    - Early zero: zero=1 with idx!=0 (short frame):
//      - sync_err=1. Discard acc; restart as a new frame from this slot.
//      - No snd_valid. Stay LOCKED.
//    - Missing zero: zero=0 with idx==0 (long frame), or any consistency mismatch:
//      - sync_err=1; acc<=0; state=UNLOCKED. snd holds.
//  - idx counts 0..17 and wraps 17->0.
//  - Contribution = op_result sign-extended when (op==1 || con==1), else 0.
//  - Accumulator is 18-bit signed; 18*4096 never overflows it.
//  - sat(): clamp to [-2^(OUTW-1), 2^(OUTW-1)-1], no scaling. +73710 -> 32767; -73728 -> -32768.
//  - Latency: snd reflects slots 0..17 of frame N on the cen cycle that presents slot 0 of frame N+1.
//  - cen=0: all state frozen; snd_valid and sync_err are forced 0 on non-cen clocks.
//  - snd_valid and sync_err are never high on the same clk.
// STRUCTURE
//  - Shared package jtopl_pkg: SLOTS, OPW, slot-index helper constant 6 (subslots per group),
//    and the state enum {UNLOCKED, LOCKED}.
//  - One sub-module, jtopl_sat (generic signed width-reduce with clamp), reused by later mixers.
//  - FSM, idx counter and accumulator stay in this module.
// TESTING
//  - Reset release, then a clean slot-counter stream with all carriers=+100, modulators=+50, con=0:
//    first zero locks with no pulse; next frame end gives snd=900 with snd_valid pulse.
//  - Same stream with con=1 on all channels -> snd=1350 every frame.
//  - All 18 slots=+4095, con=1 -> snd=32767. All slots=-4096 -> snd=-32768.
//  - Inject zero at idx=7 -> sync_err pulse, no snd_valid, snd held.
//    Next normal frame end outputs the sum of the restarted frame only.
//  - Drop zero at slot 0, or corrupt subslot once -> sync_err pulse, UNLOCKED.
//    Relock on the following zero; first valid output one full frame later.
//  - cen toggling 1-in-4 with rst asserted mid-frame:
//    - state frozen while cen=0.
//    - rst clears snd to 0 and acc; no valid until a full frame after relock.

Source files
------------

// File: rtl/jtopl_pkg.sv
// Shared constants, FSM state type and slot-position helper for the slot-serial
// operator pipeline.
package jtopl_pkg;

  localparam int unsigned SLOTS    = 18;
  localparam int unsigned OPW      = 13;
  localparam int unsigned OUTW     = 16;
  localparam int unsigned SUBSLOTS = 6;
  localparam int unsigned ACCW     = 18;
  localparam int unsigned IDXW     = 5;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } state_e;

  // Linear slot index implied by the group/subslot tags.
  function automatic logic [IDXW-1:0] slot_pos(input logic [1:0] grp, input logic [2:0] sub);
    return IDXW'(grp) * IDXW'(SUBSLOTS) + IDXW'(sub);
  endfunction

endpackage

// File: rtl/jtopl_sat.sv
// Generic signed width reduction with clamping to the output range.
module jtopl_sat #(
  parameter int unsigned IW = 18,
  parameter int unsigned OW = 16
) (
  input  logic signed [IW-1:0] din_i,
  output logic signed [OW-1:0] dout_c
);

  generate
    if (IW > OW) begin : g_clamp
      logic ovf_c;
      // Overflow whenever the bits above the output sign bit are not a pure sign extension.
      always_comb begin
        ovf_c = (din_i[IW-1:OW-1] != {(IW-OW+1){din_i[IW-1]}});
        if (!ovf_c) begin
          dout_c = din_i[OW-1:0];
        end else if (din_i[IW-1]) begin
          dout_c = {1'b1, {(OW-1){1'b0}}};
        end else begin
          dout_c = {1'b0, {(OW-1){1'b1}}};
        end
      end
    end else begin : g_ext
      assign dout_c = OW'(din_i);
    end
  endgenerate

endmodule

// File: rtl/jtopl_slot_acc.sv
// Frame-aligned accumulator at the tail of the operator pipeline: sums audible
// operators over an 18-slot frame and emits one saturated sample per frame.
module jtopl_slot_acc #(
  parameter int unsigned OPW   = jtopl_pkg::OPW,
  parameter int unsigned OUTW  = jtopl_pkg::OUTW,
  parameter int unsigned SLOTS = jtopl_pkg::SLOTS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cen,
  input  logic                   zero,
  input  logic [1:0]             group,
  input  logic [2:0]             subslot,
  input  logic                   op,
  input  logic                   con,
  input  logic signed [OPW-1:0]  op_result,
  output logic signed [OUTW-1:0] snd,
  output logic                   snd_valid,
  output logic                   sync_err
);
  import jtopl_pkg::*;

  state_e                 state_q;
  logic [IDXW-1:0]        idx_q;
  logic signed [ACCW-1:0] acc_q;

  logic signed [ACCW-1:0] contrib_c;
  logic signed [OUTW-1:0] sat_c;
  logic [IDXW-1:0]        idx_inc_c;
  logic                   fields_ok_c;

  // Carriers always sound; modulators only in additive connection.
  always_comb begin
    contrib_c   = (op | con) ? ACCW'(op_result) : '0;
    fields_ok_c = (slot_pos(group, subslot) == idx_q) && (op == (subslot >= 3'd3));
    idx_inc_c   = (idx_q == IDXW'(SLOTS - 1)) ? '0 : idx_q + IDXW'(1);
  end

  jtopl_sat #(
    .IW (ACCW),
    .OW (OUTW)
  ) u_sat (
    .din_i  (acc_q),
    .dout_c (sat_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= UNLOCKED;
      idx_q     <= '0;
      acc_q     <= '0;
      snd       <= '0;
      snd_valid <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      snd_valid <= 1'b0;
      sync_err  <= 1'b0;
      if (cen) begin
        case (state_q)
          UNLOCKED: begin
            if (zero) begin
              state_q <= LOCKED;
              idx_q   <= IDXW'(1);
              acc_q   <= contrib_c;
            end
          end
          LOCKED: begin
            if (zero && (idx_q != '0)) begin
              // Short frame: drop the partial sum and restart on this slot.
              sync_err <= 1'b1;
              idx_q    <= IDXW'(1);
              acc_q    <= contrib_c;
            end else if (!fields_ok_c || (!zero && (idx_q == '0))) begin
              sync_err <= 1'b1;
              acc_q    <= '0;
              idx_q    <= '0;
              state_q  <= UNLOCKED;
            end else if (zero) begin
              snd       <= sat_c;
              snd_valid <= 1'b1;
              acc_q     <= contrib_c;
              idx_q     <= IDXW'(1);
            end else begin
              acc_q <= acc_q + contrib_c;
              idx_q <= idx_inc_c;
            end
          end
          default: state_q <= UNLOCKED;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jtopl_slot_acc.sv
// Directed bench for jtopl_slot_acc with a frame-list reference model and per-cycle compare.
module tb_jtopl_slot_acc;

  logic               clk = 1'b0;
  logic               rst;
  logic               cen;
  logic               zero;
  logic [1:0]         group;
  logic [2:0]         subslot;
  logic               op;
  logic               con;
  logic signed [12:0] op_result;
  logic signed [15:0] snd;
  logic               snd_valid;
  logic               sync_err;

  jtopl_slot_acc dut (
    .clk       (clk),
    .rst       (rst),
    .cen       (cen),
    .zero      (zero),
    .group     (group),
    .subslot   (subslot),
    .op        (op),
    .con       (con),
    .op_result (op_result),
    .snd       (snd),
    .snd_valid (snd_valid),
    .sync_err  (sync_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_valid = 0;
  int n_err = 0;

  // Reference model: list of contributions seen in the current frame.
  int q[$];
  bit m_locked = 1'b0;
  int exp_snd = 0;
  bit exp_valid = 1'b0;
  bit exp_err = 1'b0;
  bit chk_en = 1'b0;

  function automatic int sat16(input int s);
    if (s > 32767) return 32767;
    if (s < -32768) return -32768;
    return s;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int c;
    int pos;
    int sum;
    bit ok;
    exp_valid = 1'b0;
    exp_err   = 1'b0;
    if (rst) begin
      m_locked = 1'b0;
      q.delete();
      exp_snd = 0;
    end else if (cen) begin
      c   = (op || con) ? int'(op_result) : 0;
      pos = q.size() % 18;
      ok  = ((int'(group) * 6 + int'(subslot)) == pos) && (op == (subslot >= 3'd3));
      if (!m_locked) begin
        if (zero) begin
          m_locked = 1'b1;
          q.delete();
          q.push_back(c);
        end
      end else if (zero && q.size() != 18) begin
        exp_err = 1'b1;
        q.delete();
        q.push_back(c);
      end else if (!ok || (!zero && q.size() == 18)) begin
        exp_err  = 1'b1;
        m_locked = 1'b0;
        q.delete();
      end else if (zero) begin
        sum = 0;
        foreach (q[i]) sum += q[i];
        exp_snd   = sat16(sum);
        exp_valid = 1'b1;
        q.delete();
        q.push_back(c);
      end else begin
        q.push_back(c);
      end
    end
  endtask

  // Per-cycle compare of DUT outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("snd", int'(snd), exp_snd);
      check("snd_valid", int'(snd_valid), int'(exp_valid));
      check("sync_err", int'(sync_err), int'(exp_err));
      if (snd_valid) n_valid++;
      if (sync_err) n_err++;
    end
  end

  task automatic cyc(input bit c);
    cen = c;
    @(posedge clk);
    model_step();
    chk_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic lit(input string nm, input int act, input int exp);
    #1;
    check(nm, act, exp);
  endtask

  task automatic send(input int s, input int vm, input int vc, input bit cv, input bit zv,
                      input int sub_ovr, input int gap);
    for (int g = 0; g < gap; g++) begin
      zero      = 1'($urandom_range(0, 1));
      group     = 2'($urandom_range(0, 3));
      subslot   = 3'($urandom_range(0, 7));
      op        = 1'($urandom_range(0, 1));
      con       = 1'($urandom_range(0, 1));
      op_result = 13'($urandom);
      cyc(1'b0);
    end
    zero      = zv;
    group     = 2'(s / 6);
    subslot   = 3'((sub_ovr >= 0) ? sub_ovr : s % 6);
    op        = ((s % 6) >= 3);
    con       = cv;
    op_result = 13'(((s % 6) >= 3) ? vc : vm);
    cyc(1'b1);
  endtask

  task automatic frame_part(input int from, input int to, input int vm, input int vc, input bit cv,
                            input int gap = 0, input bit drop_zero = 1'b0, input int corrupt_at = -1);
    for (int s = from; s <= to; s++) begin
      send(s, vm, vc, cv, (s == 0) && !drop_zero,
           (s == corrupt_at) ? ((s % 6) + 1) % 6 : -1, gap);
    end
  endtask

  task automatic frame(input int vm, input int vc, input bit cv, input int gap = 0);
    frame_part(0, 17, vm, vc, cv, gap);
  endtask

  int e0;
  int v0;

  initial begin
    rst = 1'b1; cen = 1'b1; zero = 1'b0; group = '0; subslot = '0;
    op = 1'b0; con = 1'b0; op_result = '0;
    @(negedge clk);
    repeat (3) cyc(1'b1);
    lit("rst_snd", int'(snd), 0);
    lit("rst_valid", int'(snd_valid), 0);
    lit("rst_err", int'(sync_err), 0);
    rst = 1'b0;

    frame(50, 100, 1'b0);
    lit("lock_no_valid", n_valid, 0);
    frame(50, 100, 1'b0);
    lit("snd_900", int'(snd), 900);
    lit("valid_cnt_1", n_valid, 1);

    frame(50, 100, 1'b1);
    frame(50, 100, 1'b1);
    lit("snd_1350", int'(snd), 1350);
    lit("valid_cnt_3", n_valid, 3);

    frame(4095, 4095, 1'b1);
    frame(-4096, -4096, 1'b1);
    lit("sat_pos", int'(snd), 32767);
    frame_part(0, 6, 10, 20, 1'b1);
    lit("sat_neg", int'(snd), -32768);
    e0 = n_err;
    v0 = n_valid;

    // Early zero at idx 7 restarts the frame.
    frame_part(0, 17, 1, 2, 1'b1);
    lit("early_err", n_err, e0 + 1);
    lit("early_no_valid", n_valid, v0);
    lit("early_snd_held", int'(snd), -32768);
    frame(3, 5, 1'b0);
    lit("restart_sum", int'(snd), 27);

    // Missing zero drops lock; relock, then output one frame later.
    frame_part(0, 17, 9, 9, 1'b0, 0, 1'b1);
    lit("drop_err", n_err, e0 + 2);
    v0 = n_valid;
    frame(7, 11, 1'b0);
    lit("relock_no_valid", n_valid, v0);
    lit("relock_snd_held", int'(snd), 27);
    frame(7, 11, 1'b0);
    lit("relock_sum", int'(snd), 99);

    // Corrupted subslot tag.
    frame_part(0, 17, 7, 11, 1'b0, 0, 1'b0, 4);
    lit("corrupt_err", n_err, e0 + 3);
    frame(2, 4, 1'b1);
    frame(2, 4, 1'b1);
    lit("post_corrupt_sum", int'(snd), 54);

    // Clock enable 1-in-4 with reset mid-frame.
    frame(20, 30, 1'b0, 3);
    frame(20, 30, 1'b0, 3);
    lit("cen_sum", int'(snd), 270);
    frame_part(0, 8, 20, 30, 1'b0, 3);
    rst = 1'b1;
    cyc(1'b0);
    cyc(1'b1);
    rst = 1'b0;
    lit("mid_rst_snd", int'(snd), 0);
    v0 = n_valid;
    frame_part(9, 17, 20, 30, 1'b0, 3);
    frame(40, 70, 1'b1, 3);
    lit("rst_relock_no_valid", n_valid, v0);
    frame(40, 70, 1'b1, 3);
    lit("rst_relock_sum", int'(snd), 990);
    lit("rst_relock_valid", n_valid, v0 + 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
